// File: rtl/mem_burst_reader.sv
// Burst reader: a small write-anytime memory plus an FSM that streams len consecutive
// words (wrapping) from base_addr over a valid/ready handshake, one word per two cycles.
module mem_burst_reader #(
   parameter int ADDR_W = 4,
   parameter int DW     = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [DW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state, state_n;
   logic [DW-1:0]     mem [DEPTH];
   logic [ADDR_W-1:0] addr, addr_n;
   logic [ADDR_W:0]   remaining, remaining_n;
   logic [DW-1:0]     out_data_n;
   logic              out_valid_n;
   logic              done_n;

   // Memory is never reset so its contents survive a mid-burst abort.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         remaining <= remaining_n;
         out_data  <= out_data_n;
         out_valid <= out_valid_n;
         done      <= done_n;
      end
   end

   // done is registered so it lines up with the DONE state, or with the idle cycle after a zero-length request.
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      remaining_n = remaining;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      done_n      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  addr_n      = base_addr;
                  remaining_n = len;
                  state_n     = FETCH;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         FETCH: begin
            out_data_n  = mem[addr];
            out_valid_n = 1'b1;
            state_n     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               remaining_n = remaining - LEN_ONE;
               if (remaining == LEN_ONE) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  addr_n  = addr + ADDR_ONE;
                  state_n = FETCH;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state == FETCH) || (state == SEND);

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; memory depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DW, default 8, data word width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  writer-side write strobe.
REQ-006 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-007 SHALL have port wr_data  input  DW  write data.
REQ-008 SHALL have port start  input  1  burst request, sampled in IDLE only.
REQ-009 SHALL have port base_addr  input  ADDR_W  first word of burst.
REQ-010 SHALL have port len  input  ADDR_W+1  number of words in burst, 0..2**ADDR_W.
REQ-011 SHALL have port out_data  output  DW  streamed word, registered.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts word.
REQ-014 SHALL have port busy  output  1  high in FETCH and SEND.
REQ-015 SHALL have port done  output  1  one-cycle burst-complete pulse.

Function
REQ-016 SHALL contain a DW x 2**ADDR_W memory; write mem[wr_addr]=wr_data on posedge CLK when wr_en=1, in any state.
REQ-017 SHALL implement states IDLE, FETCH, SEND, DONE, all registered.
REQ-018 IDLE: start=1 and len!=0 SHALL latch addr=base_addr, remaining=len, and go to FETCH next cycle.
REQ-019 IDLE: start=1 and len=0 SHALL assert done the next cycle for one cycle and remain IDLE; no word emitted.
REQ-020 FETCH: SHALL load out_data=mem[addr], set out_valid=1, go to SEND; exactly one cycle.
REQ-021 Same-cycle write and FETCH read to the same address SHALL return the old (pre-write) data.
REQ-022 SEND: out_data and out_valid SHALL stay stable while out_ready=0; no time-out.
REQ-023 SEND with out_ready=1 SHALL complete a transfer: out_valid=0 next cycle, remaining decrements by 1.
REQ-024 After a transfer with remaining=1, the block SHALL go to DONE; otherwise addr increments by 1 and returns to FETCH.
REQ-025 addr increment SHALL wrap modulo 2**ADDR_W (max address followed by 0).
REQ-026 len=2**ADDR_W SHALL emit every memory word exactly once starting at base_addr.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-028 start while busy=1 SHALL be ignored; base_addr and len SHALL be sampled only on accepted start.
REQ-029 Throughput SHALL be one word per two cycles at out_ready=1; first out_valid 2 cycles after accepted start.
REQ-030 busy SHALL be 1 exactly in FETCH and SEND.

Reset
REQ-031 RST=1 at posedge CLK SHALL force IDLE, out_valid=0, out_data=0, busy=0, done=0, addr=0, remaining=0.
REQ-032 RST mid-burst SHALL abort the burst with no further words or done pulse.
REQ-033 Memory contents SHALL NOT be affected by RST; a write with wr_en=1 during RST SHALL still occur.

Verification
REQ-034 Write mem[2..4]=8'h11,8'h22,8'h33; start base_addr=2 len=3, out_ready=1 -> 8'h11,8'h22,8'h33 on cycles 2,4,6 after start; done at cycle 7.
REQ-035 Same burst, out_ready held 0 for 5 cycles on second word -> 8'h22 stable for 6 cycles; no word lost or duplicated.
REQ-036 ADDR_W=4, base_addr=14, len=4 -> words from addresses 14,15,0,1 in order.
REQ-037 start len=0 -> done high one cycle after, busy never 1, out_valid never 1.
REQ-038 RST asserted while in SEND of a len=5 burst -> next cycle out_valid=0, busy=0; no done pulse; memory readback unchanged.
REQ-039 wr_en to addr=3 with 8'hAA in the FETCH cycle of addr 3 (old 8'h55) -> emits 8'h55; a later burst reads 8'hAA.
